// File: rtl/serial_capture.sv
// serial_capture
//   Assembles a WIDTH-bit word from a qualified serial bit stream and holds it
//   behind a valid/ready handshake. Bit order is chosen per frame by
//   msb_first, sampled together with start.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   begin (or restart) a frame; latches msb_first
//   msb_first  in   1: first bit lands in MSB, 0: first bit lands in LSB
//   bit_in     in   serial data bit
//   bit_valid  in   qualifies bit_in while shifting
//   data_out   out  held assembled word [WIDTH-1:0]
//   data_valid out  data_out holds an unconsumed word
//   data_ready in   consumer accepts data_out when high with data_valid
//   busy       out  a frame is being shifted in
//   overrun    out  sticky: a completed word was dropped (until reset)
module serial_capture #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             msb_first,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy,
   output logic             overrun
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_next;
   logic [CW-1:0]    count;
   logic             msb_lat;
   logic             take_bit;
   logic             complete;

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic             msb,
                                                 input logic             b);
      if (msb) begin
         return {cur[WIDTH-2:0], b};
      end
      return {b, cur[WIDTH-1:1]};
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: start always (re)enters SHIFT; the last bit returns to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (start)         state_nxt = SHIFT;
            else if (complete) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output / control decode. start wins over a bit arriving in the same cycle.
   always_comb begin
      busy     = (state == SHIFT);
      take_bit = (state == SHIFT) && bit_valid && !start;
      complete = take_bit && (count == LAST_BIT);
      sr_next  = shift_in(sr, msb_lat, bit_in);
   end

   // Shift register, bit counter and latched bit order
   always_ff @(posedge clk) begin
      if (reset) begin
         sr      <= '0;
         count   <= '0;
         msb_lat <= 1'b0;
      end else if (start) begin
         sr      <= '0;
         count   <= '0;
         msb_lat <= msb_first;
      end else if (take_bit) begin
         sr    <= sr_next;
         count <= count + CW'(1);
      end
   end

   // Output holding register and handshake. A completing word is accepted
   // if the holding register is empty or being drained on this same edge;
   // otherwise it is dropped and overrun latches.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (complete) begin
         if (!data_valid || data_ready) begin
            data_out   <= sr_next;
            data_valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (data_valid && data_ready) begin
         data_valid <= 1'b0;
      end
   end

endmodule
